// File: rtl/challenge_select_ctrl_pkg.sv
// Shared types and register-map constants for the challenge-select controller.
package challenge_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RUNNING = 2'd2
  } state_e;

  typedef struct packed {
    logic ack;
    logic done;
    logic abort;
  } cmd_t;

  localparam logic [1:0] ADDR_SEL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;

  localparam int ST_ERR_ZERO = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_CHANGED  = 4;

  localparam int CTRL_PEND_EN  = 0;
  localparam int CTRL_MASK_LSB = 4;
  localparam int CTRL_ACK      = 8;
  localparam int CTRL_DONE     = 9;
  localparam int CTRL_ABORT    = 10;

endpackage

// File: rtl/challenge_select_ctrl_input_debouncer.sv
// 2-FF synchronizer plus one shared debounce counter for a whole input vector.
module input_debouncer #(
  parameter int              WIDTH     = 5,
  parameter int              CYCLES    = 50000,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, cand;
  logic [CW-1:0]    cnt;

  // Any bit moving restarts the count for the whole vector; the counter
  // saturates once the candidate has been accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= RESET_VAL;
      sync2  <= RESET_VAL;
      cand   <= RESET_VAL;
      stable <= RESET_VAL;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= cand;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/challenge_select_ctrl.sv
// Avalon-MM slave for challenge-select switches and START button: debounce,
// start handshake FSM, latched challenge ID, edge capture and IRQ.
module challenge_select_ctrl
  import challenge_select_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SEL_W           = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [SEL_W-1:0] sw_in,
  input  logic             start_n,
  output logic [SEL_W-1:0] challenge_id,
  output logic             challenge_active
);

  localparam logic [SEL_W:0] DEB_RST = {1'b1, {SEL_W{1'b0}}};

  logic [SEL_W:0]   stab, stab_q;
  logic [SEL_W-1:0] stable_sel, sel_toggle;
  logic             start_pulse;

  input_debouncer #(
    .WIDTH    (SEL_W + 1),
    .CYCLES   (DEBOUNCE_CYCLES),
    .RESET_VAL(DEB_RST)
  ) u_deb (
    .clk    (clk),
    .reset_n(reset_n),
    .din    ({start_n, sw_in}),
    .stable (stab)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stab_q <= DEB_RST;
    else          stab_q <= stab;
  end

  assign stable_sel  = stab[SEL_W-1:0];
  assign sel_toggle  = stab[SEL_W-1:0] ^ stab_q[SEL_W-1:0];
  assign start_pulse = stab_q[SEL_W] & ~stab[SEL_W];

  // Bus write decode
  logic wr, wr_status, wr_ctrl, wr_edge;
  cmd_t cmd;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_status = wr && (address == ADDR_STATUS);
  assign wr_ctrl   = wr && (address == ADDR_CTRL);
  assign wr_edge   = wr && (address == ADDR_EDGE);
  assign cmd.ack   = wr_ctrl & writedata[CTRL_ACK];
  assign cmd.done  = wr_ctrl & writedata[CTRL_DONE];
  assign cmd.abort = wr_ctrl & writedata[CTRL_ABORT];
  assign unused_wd = ^{writedata[31:11], writedata[3:1]};

  // FSM
  state_e state_q, state_d;
  logic   latch_en, set_err, set_ovr, set_chg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    set_err  = 1'b0;
    set_ovr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          if (|stable_sel) begin
            state_d  = ST_PENDING;
            latch_en = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        if (cmd.abort)    state_d = ST_IDLE;
        else if (cmd.ack) state_d = ST_RUNNING;
        set_ovr = start_pulse;
      end
      ST_RUNNING: begin
        if (cmd.done || cmd.abort) state_d = ST_IDLE;
        set_ovr = start_pulse;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign set_chg = (state_q == ST_RUNNING) && (|sel_toggle);

  // Register file
  logic [2:0]       sticky, sticky_set, sticky_clr;
  logic [SEL_W-1:0] edge_q, edge_clr, edge_mask, latched_sel;
  logic             pend_en, active_q;
  logic [31:0]      rd_d;

  assign sticky_set = {set_chg, set_ovr, set_err};
  assign sticky_clr = wr_status ? writedata[ST_CHANGED:ST_ERR_ZERO] : 3'b0;
  assign edge_clr   = wr_edge ? writedata[SEL_W-1:0] : '0;

  // W1C clears first, then new events are OR-ed in so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky      <= '0;
      edge_q      <= '0;
      edge_mask   <= '0;
      pend_en     <= 1'b0;
      latched_sel <= '0;
      active_q    <= 1'b0;
      irq         <= 1'b0;
      readdata    <= '0;
    end else begin
      sticky <= (sticky & ~sticky_clr) | sticky_set;
      edge_q <= (edge_q & ~edge_clr) | sel_toggle;
      if (wr_ctrl) begin
        pend_en   <= writedata[CTRL_PEND_EN];
        edge_mask <= writedata[CTRL_MASK_LSB +: SEL_W];
      end
      if (latch_en) latched_sel <= stable_sel;
      active_q <= (state_d == ST_RUNNING);
      irq      <= (pend_en && (state_q == ST_PENDING)) || (|(edge_q & edge_mask));
      readdata <= rd_d;
    end
  end

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_SEL: begin
        rd_d[SEL_W-1:0]  = stable_sel;
        rd_d[4 +: SEL_W] = latched_sel;
      end
      ADDR_STATUS: begin
        rd_d[1:0]                    = state_q;
        rd_d[ST_CHANGED:ST_ERR_ZERO] = sticky;
      end
      ADDR_CTRL: begin
        rd_d[CTRL_PEND_EN]              = pend_en;
        rd_d[CTRL_MASK_LSB +: SEL_W]    = edge_mask;
      end
      ADDR_EDGE: rd_d[SEL_W-1:0] = edge_q;
      default:   rd_d = '0;
    endcase
  end

  assign challenge_id     = latched_sel;
  assign challenge_active = active_q;

endmodule

// File: tb/tb_challenge_select_ctrl.sv
// Self-checking bench for challenge_select_ctrl: table-driven handshake vectors,
// hand sequences for debounce/W1C/reset, and randomized switch stimulus vs a model.
module tb_challenge_select_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  sw_in = '0;
  logic        start_n = 1'b1;
  logic [3:0]  challenge_id;
  logic        challenge_active;

  challenge_select_ctrl #(.DEBOUNCE_CYCLES(4), .SEL_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .sw_in(sw_in), .start_n(start_n), .challenge_id(challenge_id),
    .challenge_active(challenge_active)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model for the switch path: the synchronised value is accepted
  // once five consecutive pin samples agree; it becomes visible two edges later.
  logic [3:0] hq[$];
  logic [3:0] stable_m, rd_m, edge_acc;
  bit         model_on = 0;

  task automatic model_reset();
    hq = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    stable_m = '0;
    rd_m = '0;
    edge_acc = '0;
  endtask

  task automatic model_step();
    logic [3:0] nxt;
    rd_m = stable_m;
    hq.push_back(sw_in);
    if (hq.size() > 7) void'(hq.pop_front());
    nxt = stable_m;
    if (hq[0] == hq[1] && hq[1] == hq[2] && hq[2] == hq[3] && hq[3] == hq[4]) nxt = hq[0];
    edge_acc |= stable_m ^ nxt;
    stable_m = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  typedef struct {
    logic [3:0]  sw;
    logic        st_n;
    logic        do_wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    int          wait_n;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic        exp_act;
    logic [3:0]  exp_id;
    string       name;
  } vec_t;

  function automatic vec_t mk(logic [3:0] sw, logic st_n, logic do_wr, logic [1:0] wa,
                              logic [31:0] wd, int w, logic [1:0] ra, logic [31:0] er,
                              logic ei, logic ea, logic [3:0] eid, string nm);
    vec_t v;
    v.sw = sw; v.st_n = st_n; v.do_wr = do_wr; v.waddr = wa; v.wdata = wd;
    v.wait_n = w; v.raddr = ra; v.exp_rd = er; v.exp_irq = ei; v.exp_act = ea;
    v.exp_id = eid; v.name = nm;
    return v;
  endfunction

  vec_t tbl[$];
  bit   seen7, seen_e, seen_i;
  int   runlen;

  initial begin
    // handshake / zero-select / RUNNING-event vectors (address 0 SEL,1 STATUS,2 CTRL,3 EDGE)
    tbl.push_back(mk(4'h3, 1, 1, 2, 32'h001, 12, 0, 32'h03, 0, 0, 4'h0, "hs_sel_idle"));
    tbl.push_back(mk(4'h3, 0, 0, 0, 32'h000, 12, 1, 32'h01, 1, 0, 4'h3, "hs_pending"));
    tbl.push_back(mk(4'h3, 1, 0, 0, 32'h000, 12, 0, 32'h33, 1, 0, 4'h3, "hs_latched"));
    tbl.push_back(mk(4'h3, 1, 1, 2, 32'h101,  3, 1, 32'h02, 0, 1, 4'h3, "hs_ack_run"));
    tbl.push_back(mk(4'h3, 1, 0, 0, 32'h000,  1, 2, 32'h01, 0, 1, 4'h3, "ctrl_rdback"));
    tbl.push_back(mk(4'h3, 1, 1, 2, 32'h201,  3, 1, 32'h00, 0, 0, 4'h3, "hs_done"));
    tbl.push_back(mk(4'h0, 1, 0, 0, 32'h000, 12, 1, 32'h00, 0, 0, 4'h3, "zero_idle"));
    tbl.push_back(mk(4'h0, 0, 0, 0, 32'h000, 12, 1, 32'h04, 0, 0, 4'h3, "zero_err"));
    tbl.push_back(mk(4'h0, 1, 1, 1, 32'h004, 12, 1, 32'h00, 0, 0, 4'h3, "zero_w1c"));
    tbl.push_back(mk(4'h3, 1, 0, 0, 32'h000, 12, 0, 32'h33, 0, 0, 4'h3, "ev_sel"));
    tbl.push_back(mk(4'h3, 0, 0, 0, 32'h000, 12, 1, 32'h01, 1, 0, 4'h3, "ev_pending"));
    tbl.push_back(mk(4'h3, 1, 1, 2, 32'h101, 12, 1, 32'h02, 0, 1, 4'h3, "ev_running"));
    tbl.push_back(mk(4'h9, 1, 0, 0, 32'h000, 12, 1, 32'h12, 0, 1, 4'h3, "ev_changed"));
    tbl.push_back(mk(4'h9, 0, 0, 0, 32'h000, 12, 1, 32'h1A, 0, 1, 4'h3, "ev_overrun"));
    tbl.push_back(mk(4'h9, 1, 1, 2, 32'h401, 12, 1, 32'h18, 0, 0, 4'h3, "ev_abort_run"));
    tbl.push_back(mk(4'h9, 0, 0, 0, 32'h000, 12, 1, 32'h19, 1, 0, 4'h9, "ev_pending2"));
    tbl.push_back(mk(4'h9, 1, 1, 2, 32'h501, 12, 1, 32'h18, 0, 0, 4'h9, "ack_abort_pend"));
    tbl.push_back(mk(4'h9, 1, 1, 1, 32'h01C,  2, 1, 32'h00, 0, 0, 4'h9, "sticky_w1c"));
    tbl.push_back(mk(4'h9, 1, 0, 0, 32'h000,  1, 0, 32'h99, 0, 0, 4'h9, "sel_after"));
    tbl.push_back(mk(4'h9, 1, 1, 2, 32'h101,  3, 1, 32'h00, 0, 0, 4'h9, "ack_in_idle"));

    // reset values
    run(3);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_active", challenge_active, 1'b0);
    reset_n = 1'b1;
    address = 2'd1;
    tick();
    chk("rst_status", readdata, 32'h0);

    // debounce with a 2-cycle glitch
    address = 2'd0;
    seen7 = 0;
    sw_in = 4'h5; run(2);
    if (readdata[3:0] == 4'h7) seen7 = 1;
    sw_in = 4'h7; run(2);
    if (readdata[3:0] == 4'h7) seen7 = 1;
    sw_in = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (readdata[3:0] == 4'h7) seen7 = 1;
    end
    chk("deb_not_yet", readdata[3:0], 4'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (readdata[3:0] == 4'h7) seen7 = 1;
    end
    chk("deb_sel5", readdata[3:0], 4'h5);
    chk("deb_no_glitch", seen7, 1'b0);
    address = 2'd3;
    tick();
    chk("deb_edge", readdata, 32'h5);

    // table-driven handshake vectors
    for (int i = 0; i < tbl.size(); i++) begin
      sw_in = tbl[i].sw;
      start_n = tbl[i].st_n;
      if (tbl[i].do_wr) bus_wr(tbl[i].waddr, tbl[i].wdata);
      run(tbl[i].wait_n);
      address = tbl[i].raddr;
      tick();
      chk({tbl[i].name, "_rd"}, readdata, tbl[i].exp_rd);
      chk({tbl[i].name, "_irq"}, irq, tbl[i].exp_irq);
      chk({tbl[i].name, "_act"}, challenge_active, tbl[i].exp_act);
      chk({tbl[i].name, "_id"}, challenge_id, tbl[i].exp_id);
    end

    // edge IRQ, then W1C racing a fresh toggle
    bus_wr(2'd3, 32'hF);
    bus_wr(2'd2, 32'h010);
    sw_in = 4'h8;
    run(12);
    address = 2'd3;
    tick();
    chk("edge_bit0", readdata, 32'h1);
    chk("edge_irq", irq, 1'b1);
    sw_in = 4'h9;
    seen_e = 0; seen_i = 0;
    for (int k = 0; k < 12; k++) begin
      chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h1;
      tick();
      if (k >= 3 && readdata[0]) seen_e = 1;
      if (k >= 3 && irq) seen_i = 1;
    end
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    chk("w1c_set_wins_edge", seen_e, 1'b1);
    chk("w1c_set_wins_irq", seen_i, 1'b1);
    run(3);
    tick();
    chk("edge_cleared", readdata, 32'h0);
    chk("edge_irq_clr", irq, 1'b0);

    // reset in the middle of a running challenge with sticky bits set
    start_n = 1'b0; run(12);
    start_n = 1'b1; run(12);
    bus_wr(2'd2, 32'h101);
    run(3);
    chk("pre_rst_active", challenge_active, 1'b1);
    chk("pre_rst_id", challenge_id, 4'h9);
    sw_in = 4'h3; run(12);
    reset_n = 1'b0;
    run(2);
    chk("mid_rst_readdata", readdata, 32'h0);
    chk("mid_rst_irq", irq, 1'b0);
    chk("mid_rst_active", challenge_active, 1'b0);
    chk("mid_rst_id", challenge_id, 4'h0);
    model_reset();
    model_on = 1;
    reset_n = 1'b1;
    address = 2'd1;
    tick();
    chk("post_rst_status", readdata, 32'h0);
    chk("post_rst_irq", irq, 1'b0);

    // randomized switch activity vs reference model
    bus_wr(2'd2, 32'h0F0);
    address = 2'd0;
    runlen = 0;
    for (int c = 0; c < 400; c++) begin
      if (runlen == 0) begin
        sw_in = 4'($urandom_range(0, 15));
        runlen = $urandom_range(1, 9);
      end
      runlen--;
      tick();
      chk("rand_sel", {28'h0, readdata[3:0]}, {28'h0, rd_m});
    end
    run(12);
    tick();
    chk("rand_sel_final", {28'h0, readdata[3:0]}, {28'h0, stable_m});
    address = 2'd3;
    tick();
    chk("rand_edge", readdata, {28'h0, edge_acc});
    chk("rand_irq", irq, |edge_acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
